// File: rtl/biu_access_tracker.sv
// -----------------------------------------------------------------------------
// biu_access_tracker
//
// Follows core BIU request/acknowledge traffic and turns each completed access
// into a single registered record for the task-monitor logging stage.
// Requests are queued in order with their context. Each acknowledge retires
// the oldest entry. Read data is merged in, and an address window decides
// whether the access is emitted as a record.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   req_i          access request accepted this cycle
//   adr_i, d_i     request address / write data
//   we_i           1 = write, 0 = read
//   size_i         access size (biu_size_t encoding, 2 bits)
//   sp_i, ra_i     core sp / ra captured with the request
//   ack_i          completion of the oldest outstanding request
//   q_i            read data, valid together with ack_i
//   rec_valid_o    one-cycle strobe, record fields valid
//   rec_*_o        record fields; they hold until the next emitted record
//   outstanding_o  FIFO occupancy after the last edge
//   rec_cnt_o      number of records emitted (wraps)
//   overflow_o     sticky: a request was dropped because the FIFO was full
//   orphan_o       sticky: an ack arrived with nothing outstanding
// -----------------------------------------------------------------------------
module biu_access_tracker #(
  parameter int unsigned       XLEN          = 32,
  parameter int unsigned       DEPTH         = 4,
  parameter logic [XLEN-1:0]   ADDRESS_BASE  = 'h0000_0000,
  parameter logic [XLEN-1:0]   ADDRESS_RANGE = 'h4000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic [XLEN-1:0]            adr_i,
  input  logic [XLEN-1:0]            d_i,
  input  logic                       we_i,
  input  logic [1:0]                 size_i,
  input  logic [XLEN-1:0]            sp_i,
  input  logic [XLEN-1:0]            ra_i,
  input  logic                       ack_i,
  input  logic [XLEN-1:0]            q_i,
  output logic                       rec_valid_o,
  output logic [XLEN-1:0]            rec_adr_o,
  output logic [XLEN-1:0]            rec_data_o,
  output logic [XLEN-1:0]            rec_sp_o,
  output logic [XLEN-1:0]            rec_ra_o,
  output logic                       rec_we_o,
  output logic [1:0]                 rec_size_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic [31:0]                rec_cnt_o,
  output logic                       overflow_o,
  output logic                       orphan_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // Entry storage. It needs no reset because occupancy gates every read.
  logic [XLEN-1:0] adr_mem [DEPTH];
  logic [XLEN-1:0] d_mem   [DEPTH];
  logic [XLEN-1:0] sp_mem  [DEPTH];
  logic [XLEN-1:0] ra_mem  [DEPTH];
  logic            we_mem  [DEPTH];
  logic [1:0]      sz_mem  [DEPTH];

  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic            rec_valid_q;
  logic [XLEN-1:0] rec_adr_q, rec_data_q, rec_sp_q, rec_ra_q;
  logic            rec_we_q;
  logic [1:0]      rec_size_q;
  logic [31:0]     rec_cnt_q;
  logic            overflow_q, orphan_q;

  logic            empty, full, pop, push, drop, orphan, in_range, emit;
  logic [XLEN-1:0] head_adr;
  logic [XLEN:0]   win_end;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  // Pop depends only on occupancy before the edge. A request arriving in the
  // same cycle can never satisfy its own ack.
  assign pop    = ack_i && !empty;
  assign orphan = ack_i && empty;
  // A full FIFO can still accept a request when the head leaves in the same cycle.
  assign push   = req_i && (!full || pop);
  assign drop   = req_i && full && !pop;

  // The window end uses one extra bit so that BASE+RANGE cannot wrap to zero.
  assign head_adr = adr_mem[rd_ptr_q];
  assign win_end  = {1'b0, ADDRESS_BASE} + {1'b0, ADDRESS_RANGE};
  assign in_range = (head_adr >= ADDRESS_BASE) && ({1'b0, head_adr} < win_end);
  assign emit     = pop && in_range;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      adr_mem[wr_ptr_q] <= adr_i;
      d_mem[wr_ptr_q]   <= d_i;
      sp_mem[wr_ptr_q]  <= sp_i;
      ra_mem[wr_ptr_q]  <= ra_i;
      we_mem[wr_ptr_q]  <= we_i;
      sz_mem[wr_ptr_q]  <= size_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rec_valid_q <= 1'b0;
      rec_adr_q   <= '0;
      rec_data_q  <= '0;
      rec_sp_q    <= '0;
      rec_ra_q    <= '0;
      rec_we_q    <= 1'b0;
      rec_size_q  <= '0;
      rec_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      rec_valid_q <= emit;
      if (emit) begin
        rec_adr_q  <= head_adr;
        // Reads take the acknowledge data. Writes report the data they stored.
        rec_data_q <= we_mem[rd_ptr_q] ? d_mem[rd_ptr_q] : q_i;
        rec_sp_q   <= sp_mem[rd_ptr_q];
        rec_ra_q   <= ra_mem[rd_ptr_q];
        rec_we_q   <= we_mem[rd_ptr_q];
        rec_size_q <= sz_mem[rd_ptr_q];
        rec_cnt_q  <= rec_cnt_q + 32'd1;
      end
      if (drop)   overflow_q <= 1'b1;
      if (orphan) orphan_q   <= 1'b1;
    end
  end

  assign rec_valid_o   = rec_valid_q;
  assign rec_adr_o     = rec_adr_q;
  assign rec_data_o    = rec_data_q;
  assign rec_sp_o      = rec_sp_q;
  assign rec_ra_o      = rec_ra_q;
  assign rec_we_o      = rec_we_q;
  assign rec_size_o    = rec_size_q;
  assign outstanding_o = count_q;
  assign rec_cnt_o     = rec_cnt_q;
  assign overflow_o    = overflow_q;
  assign orphan_o      = orphan_q;

endmodule

// File: tb/tb_biu_access_tracker.sv
// -----------------------------------------------------------------------------
// tb_biu_access_tracker
//
// Drives request/ack traffic through biu_access_tracker. A small outstanding
// queue model decides which request each ack retires. It pushes the expected
// record onto a scoreboard. A negedge monitor pops the scoreboard whenever
// the DUT strobes a record. It also checks the status outputs every cycle.
// -----------------------------------------------------------------------------
module tb_biu_access_tracker;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] RANGE = 32'h0000_4000;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] d;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] sp;
    logic [31:0] ra;
  } entry_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, ack_i;
  logic [31:0] adr_i, d_i, sp_i, ra_i, q_i;
  logic [1:0]  size_i;
  logic        rec_valid_o, rec_we_o, overflow_o, orphan_o;
  logic [31:0] rec_adr_o, rec_data_o, rec_sp_o, rec_ra_o, rec_cnt_o;
  logic [1:0]  rec_size_o;
  logic [2:0]  outstanding_o;

  biu_access_tracker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ADDRESS_BASE(BASE), .ADDRESS_RANGE(RANGE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .adr_i(adr_i), .d_i(d_i), .we_i(we_i), .size_i(size_i),
    .sp_i(sp_i), .ra_i(ra_i), .ack_i(ack_i), .q_i(q_i),
    .rec_valid_o(rec_valid_o), .rec_adr_o(rec_adr_o), .rec_data_o(rec_data_o),
    .rec_sp_o(rec_sp_o), .rec_ra_o(rec_ra_o), .rec_we_o(rec_we_o),
    .rec_size_o(rec_size_o), .outstanding_o(outstanding_o),
    .rec_cnt_o(rec_cnt_o), .overflow_o(overflow_o), .orphan_o(orphan_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  entry_t      mq[$];     // model of outstanding requests
  entry_t      expq[$];   // scoreboard of expected records
  logic        exp_emit   = 1'b0;
  logic        exp_ovf    = 1'b0;
  logic        exp_orphan = 1'b0;
  logic [31:0] exp_cnt    = '0;
  bit          mon_en     = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle of stimulus. The call starts just after a rising edge and
  // returns just after the next one, with the model updated to post-edge state.
  task automatic cyc(input logic req, input logic [31:0] adr, input logic [31:0] d,
                     input logic we, input logic [1:0] sz, input logic [31:0] sp,
                     input logic [31:0] ra, input logic ack, input logic [31:0] q);
    entry_t e, h;
    bit     do_pop, do_push;
    req_i = req; adr_i = adr; d_i = d; we_i = we; size_i = sz;
    sp_i = sp; ra_i = ra; ack_i = ack; q_i = q;
    e.adr = adr; e.d = d; e.we = we; e.sz = sz; e.sp = sp; e.ra = ra;
    do_pop  = ack && (mq.size() != 0);
    do_push = req && ((mq.size() < DEPTH) || do_pop);
    @(posedge clk_i);
    #1;
    exp_emit = 1'b0;
    if (ack && !do_pop) exp_orphan = 1'b1;
    if (req && !do_push) exp_ovf = 1'b1;
    if (do_pop) begin
      h = mq.pop_front();
      if (!h.we) h.d = q;
      if ((longint'(h.adr) >= longint'(BASE)) &&
          (longint'(h.adr) < longint'(BASE) + longint'(RANGE))) begin
        expq.push_back(h);
        exp_emit = 1'b1;
        exp_cnt  = exp_cnt + 32'd1;
      end
    end
    if (do_push) mq.push_back(e);
    req_i = 1'b0; ack_i = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 2'd0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [31:0] adr);
    cyc(1'b1, adr, '0, 1'b0, 2'd2, 32'h3F00 + adr, 32'h200 + adr, 1'b0, '0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    cyc(1'b1, adr, d, 1'b1, 2'd2, 32'h3F00 + adr, 32'h200 + adr, 1'b0, '0);
  endtask

  task automatic ack(input logic [31:0] q);
    cyc(1'b0, '0, '0, 1'b0, 2'd0, '0, '0, 1'b1, q);
  endtask

  // Assert reset away from any clock edge. Check that outputs clear at once,
  // then release the reset just after a rising edge.
  task automatic do_reset();
    #2;
    rst_ni = 1'b0;
    mq.delete(); expq.delete();
    exp_emit = 1'b0; exp_ovf = 1'b0; exp_orphan = 1'b0; exp_cnt = '0;
    #1;
    check_eq("rst_valid",       32'(rec_valid_o),   0);
    check_eq("rst_outstanding", 32'(outstanding_o), 0);
    check_eq("rst_adr",         rec_adr_o,          0);
    check_eq("rst_data",        rec_data_o,         0);
    check_eq("rst_sp",          rec_sp_o,           0);
    check_eq("rst_ra",          rec_ra_o,           0);
    check_eq("rst_we_size",     {29'd0, rec_we_o, rec_size_o}, 0);
    check_eq("rst_cnt",         rec_cnt_o,          0);
    check_eq("rst_flags",       {30'd0, overflow_o, orphan_o}, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      entry_t x;
      check_eq("outstanding", 32'(outstanding_o), mq.size());
      check_eq("overflow",    32'(overflow_o),    32'(exp_ovf));
      check_eq("orphan",      32'(orphan_o),      32'(exp_orphan));
      check_eq("rec_cnt",     rec_cnt_o,          exp_cnt);
      check_eq("rec_valid",   32'(rec_valid_o),   32'(exp_emit));
      if (rec_valid_o === 1'b1) begin
        check_eq("sb_nonempty", 32'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          x = expq.pop_front();
          $display("rec #%0d adr=0x%08h data=0x%08h we=%0b sz=%0d sp=0x%08h ra=0x%08h",
                   rec_cnt_o, rec_adr_o, rec_data_o, rec_we_o, rec_size_o, rec_sp_o, rec_ra_o);
          check_eq("rec_adr",  rec_adr_o,         x.adr);
          check_eq("rec_data", rec_data_o,        x.d);
          check_eq("rec_sp",   rec_sp_o,          x.sp);
          check_eq("rec_ra",   rec_ra_o,          x.ra);
          check_eq("rec_we",   32'(rec_we_o),     32'(x.we));
          check_eq("rec_size", 32'(rec_size_o),   32'(x.sz));
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    req_i = 1'b0; ack_i = 1'b0; we_i = 1'b0; size_i = '0;
    adr_i = '0; d_i = '0; sp_i = '0; ra_i = '0; q_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Single read with sp/ra echo.
    cyc(1'b1, 32'h100, '0, 1'b0, 2'd2, 32'h3F00, 32'h200, 1'b0, '0);
    ack(32'hDEAD_BEEF);
    idle();
    check_eq("single_cnt", rec_cnt_o, 32'd1);

    // Pipelined write/read mix.
    wr(32'h10, 32'd1);
    rd(32'h14);
    wr(32'h18, 32'd3);
    rd(32'h1C);
    check_eq("pipe_peak", 32'(outstanding_o), 32'd4);
    idle();
    ack(32'hAAAA_0001);
    ack(32'hAAAA_0002);
    ack(32'hBBBB_0003);
    ack(32'hBBBB_0004);
    idle();

    // Overflow: the fifth request is dropped.
    for (int i = 0; i < 5; i++) rd(32'h20 + 32'(4 * i));
    check_eq("ovf_full", 32'(outstanding_o), 32'd4);
    for (int i = 0; i < 4; i++) ack(32'hC000_0000 + 32'(i));
    idle();

    do_reset();

    // Full FIFO with a simultaneous request and ack.
    for (int i = 0; i < 4; i++) wr(32'h50 + 32'(4 * i), 32'h500 + 32'(i));
    cyc(1'b1, 32'h60, 32'h600, 1'b1, 2'd1, 32'h3F60, 32'h260, 1'b1, 32'h0);
    check_eq("full_pushpop", 32'(outstanding_o), 32'd4);
    for (int i = 0; i < 4; i++) ack(32'h0);
    idle();

    // Orphan ack on empty FIFO with a request in the same cycle.
    cyc(1'b1, 32'h40, '0, 1'b0, 2'd0, 32'h3F40, 32'h240, 1'b1, 32'h1234_5678);
    check_eq("orphan_occ", 32'(outstanding_o), 32'd1);
    ack(32'h1234_5678);
    idle();

    // Window boundary: 'h4000 is just outside, 'h3FFC is just inside.
    wr(32'h4000, 32'h4444);
    rd(32'h3FFC);
    ack(32'h0);
    ack(32'h3FFC_0000);
    idle();

    // Reset with requests still outstanding.
    rd(32'h80);
    rd(32'h84);
    check_eq("pre_rst_occ", 32'(outstanding_o), 32'd2);
    do_reset();
    idle();
    idle();

    check_eq("sb_drained", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
